// File: rtl/status_reg_if.sv
// Status register port bundle: ALU flag inputs, flag/IE/stack commands, flag and stack outputs.
// Latency: none; this is a wiring bundle only.
// Backpressure: none; every command is accepted in the cycle it is presented.
interface status_reg_if;
    // ALU flags and commands (driven by the core)
    logic       alu_cout;
    logic       alu_zout;
    logic       alu_nout;
    logic [2:0] fl_we;      // {C,Z,N}
    logic       sc;
    logic       cc;
    logic       ie_set;
    logic       ie_clr;
    logic       st_we;
    logic [7:0] st_din;     // [3:0] = {I,N,Z,C}
    logic       save;
    logic       restore;
    logic       err_clr;
    // Registered flags and stack state (driven by the status register)
    logic       carry;
    logic       zero;
    logic       neg;
    logic       ie;
    logic [7:0] status;
    logic       full;
    logic       empty;
    logic       ovf_err;
    logic       unf_err;

    modport master (
        output alu_cout, alu_zout, alu_nout, fl_we, sc, cc, ie_set, ie_clr,
               st_we, st_din, save, restore, err_clr,
        input  carry, zero, neg, ie, status, full, empty, ovf_err, unf_err
    );

    modport slave (
        input  alu_cout, alu_zout, alu_nout, fl_we, sc, cc, ie_set, ie_clr,
               st_we, st_din, save, restore, err_clr,
        output carry, zero, neg, ie, status, full, empty, ovf_err, unf_err
    );
endinterface

// File: rtl/status_reg.sv
// Processor status register: ALU flags, interrupt enable, optional shadow stack (STATUS_SHADOW_EN).
// Latency: one cycle from command sample to visible flags; outputs are purely registered.
// Backpressure: none; stack overflow/underflow are flagged in sticky error bits instead.
module status_reg #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    status_reg_if.slave   bus
);
    // Flag vector layout is {I,N,Z,C} throughout, matching the stack entry format.
    logic [3:0] flags_q, flags_d;
    logic [3:0] upd_flags;

    // Flag/IE update class: fl_we loads ALU flags, sc/cc override carry, paired set+clear cancels.
    always_comb begin
        upd_flags = flags_q;
        if (bus.fl_we[2]) upd_flags[0] = bus.alu_cout;
        if (bus.fl_we[1]) upd_flags[1] = bus.alu_zout;
        if (bus.fl_we[0]) upd_flags[2] = bus.alu_nout;
        if (bus.sc && !bus.cc) upd_flags[0] = 1'b1;
        else if (bus.cc && !bus.sc) upd_flags[0] = 1'b0;
        if (bus.ie_set && !bus.ie_clr) upd_flags[3] = 1'b1;
        else if (bus.ie_clr && !bus.ie_set) upd_flags[3] = 1'b0;
    end

    // Upper software-write bits carry no state.
    logic [3:0] unused_din;
    assign unused_din = bus.st_din[7:4];

`ifdef STATUS_SHADOW_EN
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = $clog2(DEPTH);

    logic [3:0]     stack_q [DEPTH];
    logic [SPW-1:0] sp_q, sp_d;
    logic [SPW-1:0] sp_dec;
    logic           ovf_q, ovf_d;
    logic           unf_q, unf_d;
    logic           push_w;
    logic           full_w, empty_w;
    logic [IW-1:0]  wr_idx, rd_idx;

    assign full_w  = (sp_q == SPW'(DEPTH));
    assign empty_w = (sp_q == '0);
    assign sp_dec  = sp_q - 1'b1;
    assign wr_idx  = sp_q[IW-1:0];
    assign rd_idx  = sp_dec[IW-1:0];

    // Command priority: restore, save, software write, flag updates; errors are sticky.
    always_comb begin
        flags_d = flags_q;
        sp_d    = sp_q;
        push_w  = 1'b0;
        ovf_d   = ovf_q & ~bus.err_clr;
        unf_d   = unf_q & ~bus.err_clr;
        if (bus.restore) begin
            if (!empty_w) begin
                flags_d = stack_q[rd_idx];
                sp_d    = sp_dec;
            end else begin
                unf_d   = 1'b1;
            end
        end else if (bus.save) begin
            if (!full_w) begin
                push_w  = 1'b1;
                sp_d    = sp_q + 1'b1;
            end else begin
                ovf_d   = 1'b1;
            end
            flags_d[3] = 1'b0;
        end else if (bus.st_we) begin
            flags_d = bus.st_din[3:0];
        end else begin
            flags_d = upd_flags;
        end
    end

    // Stack storage needs no reset: entries above sp are never read.
    always_ff @(posedge clk) begin
        if (push_w) stack_q[wr_idx] <= flags_q;
    end

    // Flag, pointer and error state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_q <= '0;
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.full    = full_w;
    assign bus.empty   = empty_w;
    assign bus.ovf_err = ovf_q;
    assign bus.unf_err = unf_q;
`else
    // Without the stack, save/restore only drop/raise interrupt enable.
    always_comb begin
        flags_d = flags_q;
        if (bus.restore) begin
            flags_d[3] = 1'b1;
        end else if (bus.save) begin
            flags_d[3] = 1'b0;
        end else if (bus.st_we) begin
            flags_d = bus.st_din[3:0];
        end else begin
            flags_d = upd_flags;
        end
    end

    // Flag state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) flags_q <= '0;
        else      flags_q <= flags_d;
    end

    // Error clear and stack depth have nothing to act on in this build.
    logic unused_cfg;
    assign unused_cfg = bus.err_clr ^ (DEPTH > 16);

    assign bus.full    = 1'b0;
    assign bus.empty   = 1'b1;
    assign bus.ovf_err = 1'b0;
    assign bus.unf_err = 1'b0;
`endif

    assign bus.carry  = flags_q[0];
    assign bus.zero   = flags_q[1];
    assign bus.neg    = flags_q[2];
    assign bus.ie     = flags_q[3];
    assign bus.status = {4'b0000, flags_q};
endmodule

// File: tb/tb_status_reg.sv
// Bench for status_reg: directed vectors, queue-based reference model, per-cycle compare.
// Latency: outputs compared one cycle after each command edge.
// Backpressure: none exercised; stack overflow/underflow checked through the error bits.
module tb_status_reg;
    localparam int DEPTH = 4;
`ifdef STATUS_SHADOW_EN
    localparam bit SH = 1'b1;
`else
    localparam bit SH = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    status_reg_if bus();

    status_reg #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference model: flags {I,N,Z,C}, stack as a queue, sticky errors.
    logic [3:0] m_fl;
    logic [3:0] m_stk[$];
    bit         m_ovf, m_unf;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_fl  = 4'h0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    function automatic void m_step();
        bit ov = 1'b0;
        bit un = 1'b0;
        if (bus.restore) begin
            if (SH) begin
                if (m_stk.size() > 0) m_fl = m_stk.pop_back();
                else un = 1'b1;
            end else begin
                m_fl[3] = 1'b1;
            end
        end else if (bus.save) begin
            if (SH) begin
                if (m_stk.size() < DEPTH) m_stk.push_back(m_fl);
                else ov = 1'b1;
            end
            m_fl[3] = 1'b0;
        end else if (bus.st_we) begin
            m_fl = bus.st_din[3:0];
        end else begin
            if (bus.sc != bus.cc) m_fl[0] = bus.sc;
            else if (bus.fl_we[2]) m_fl[0] = bus.alu_cout;
            if (bus.fl_we[1]) m_fl[1] = bus.alu_zout;
            if (bus.fl_we[0]) m_fl[2] = bus.alu_nout;
            if (bus.ie_set != bus.ie_clr) m_fl[3] = bus.ie_set;
        end
        if (SH) begin
            if (bus.err_clr) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (ov) m_ovf = 1'b1;
            if (un) m_unf = 1'b1;
        end
    endfunction

    // Every falling edge: all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("status", bus.status, {4'b0000, m_fl});
            chk("carry",  8'(bus.carry), 8'(m_fl[0]));
            chk("zero",   8'(bus.zero),  8'(m_fl[1]));
            chk("neg",    8'(bus.neg),   8'(m_fl[2]));
            chk("ie",     8'(bus.ie),    8'(m_fl[3]));
            chk("full",   8'(bus.full),  8'(SH && (m_stk.size() == DEPTH)));
            chk("empty",  8'(bus.empty), 8'(!SH || (m_stk.size() == 0)));
            chk("ovf",    8'(bus.ovf_err), 8'(m_ovf));
            chk("unf",    8'(bus.unf_err), 8'(m_unf));
        end
    end

    task automatic idle();
        bus.alu_cout = 1'b0;
        bus.alu_zout = 1'b0;
        bus.alu_nout = 1'b0;
        bus.fl_we    = 3'b000;
        bus.sc       = 1'b0;
        bus.cc       = 1'b0;
        bus.ie_set   = 1'b0;
        bus.ie_clr   = 1'b0;
        bus.st_we    = 1'b0;
        bus.st_din   = 8'h00;
        bus.save     = 1'b0;
        bus.restore  = 1'b0;
        bus.err_clr  = 1'b0;
    endtask

    // One clock: DUT and model both take the currently driven command.
    task automatic tick();
        @(posedge clk);
        if (rst) m_step();
        @(negedge clk);
        #1;
        idle();
    endtask

    task automatic wr(input logic [7:0] d);
        bus.st_we  = 1'b1;
        bus.st_din = d;
        tick();
    endtask

    initial begin
        idle();
        m_reset();
        rst = 1'b0;
        chk_en = 1'b1;
        #12;
        chk("rst_status", bus.status, 8'h00);
        chk("rst_empty", 8'(bus.empty), 8'h01);
        chk("rst_full", 8'(bus.full), 8'h00);
        @(negedge clk);
        rst = 1'b1;
        #1;

        // ALU flag load
        bus.fl_we = 3'b111; bus.alu_cout = 1'b1; bus.alu_nout = 1'b1;
        tick();
        chk("alu_status", bus.status, 8'h05);
        chk("alu_carry", 8'(bus.carry), 8'h01);

        // save / flag op / restore round trip
        wr(8'h09);
        chk("seq0", bus.status, 8'h09);
        bus.save = 1'b1; tick();
        chk("seq1", bus.status, 8'h01);
        bus.fl_we = 3'b111; tick();
        chk("seq2", bus.status, 8'h00);
        bus.restore = 1'b1; tick();
        chk("seq3", bus.status, SH ? 8'h09 : 8'h08);
        chk("seq_empty", 8'(bus.empty), 8'h01);

        // Overflow / underflow / error clear
        wr(8'h00);
        for (int i = 0; i < 5; i++) begin
            bus.save = 1'b1; tick();
            if (i == 3) chk("full4", 8'(bus.full), 8'(SH));
        end
        chk("ovf5", 8'(bus.ovf_err), 8'(SH));
        chk("full5", 8'(bus.full), 8'(SH));
        for (int i = 0; i < 5; i++) begin
            bus.restore = 1'b1; tick();
        end
        chk("unf5", 8'(bus.unf_err), 8'(SH));
        bus.restore = 1'b1; bus.err_clr = 1'b1; tick();
        chk("unf_win", 8'(bus.unf_err), 8'(SH));
        chk("ovf_clr", 8'(bus.ovf_err), 8'h00);
        bus.err_clr = 1'b1; tick();
        chk("unf_clr", 8'(bus.unf_err), 8'h00);

        // Carry override and IE cancel
        wr(8'h08);
        bus.sc = 1'b1; bus.cc = 1'b1; bus.fl_we = 3'b100; bus.alu_cout = 1'b1;
        bus.ie_set = 1'b1; bus.ie_clr = 1'b1;
        tick();
        chk("sccc", bus.status, 8'h09);
        bus.cc = 1'b1; bus.fl_we = 3'b100; bus.alu_cout = 1'b1; tick();
        chk("cc_ovr", bus.status, 8'h08);
        bus.sc = 1'b1; bus.fl_we = 3'b100; tick();
        chk("sc_ovr", bus.status, 8'h09);
        bus.ie_clr = 1'b1; tick();
        chk("ie_clr", bus.status, 8'h01);

        // restore beats save and software write
        wr(8'h06);
        bus.save = 1'b1; tick();
        wr(8'h01);
        bus.save = 1'b1; bus.restore = 1'b1; bus.st_we = 1'b1; bus.st_din = 8'h0F;
        tick();
        chk("prio", bus.status, SH ? 8'h06 : 8'h09);
        chk("prio_empty", 8'(bus.empty), 8'h01);

        // Asynchronous reset mid-stack
        wr(8'h0B);
        bus.save = 1'b1; tick();
        bus.save = 1'b1; tick();
        #2;
        rst = 1'b0;
        m_reset();
        #1;
        chk("arst_status", bus.status, 8'h00);
        chk("arst_empty", 8'(bus.empty), 8'h01);
        chk("arst_full", 8'(bus.full), 8'h00);
        @(negedge clk);
        rst = 1'b1;
        #1;
        bus.restore = 1'b1; tick();
        chk("post_unf", 8'(bus.unf_err), 8'(SH));
        chk("post_status", bus.status, SH ? 8'h00 : 8'h08);

        tick();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/status_reg.md
# status_reg

Processor status register for the tinySoC core, sitting directly downstream of the 8-bit ALU. It holds the ALU's condition flags and feeds carry back as the ALU's `cin` on the next cycle. It also provides the interrupt-enable bit and a hardware shadow stack that saves flags on interrupt entry and restores them on return.

## Interface
- `DEPTH`, 4: shadow stack entries (2–16); each entry is {I,N,Z,C}.
- `clk`  in  1  core clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous active-low reset.
- `alu_cout`, `alu_zout`, `alu_nout`  in  1 each  ALU flag outputs, current cycle.
- `fl_we`  in  3  per-flag write mask {C,Z,N}; a set bit loads that flag from the ALU.
- `sc`, `cc`  in  1 each  set carry, clear carry.
- `ie_set`, `ie_clr`  in  1 each  set or clear interrupt enable I.
- `st_we`  in  1  software write of the status register from `st_din`.
- `st_din`  in  8  software write data; bits [3:0] = {I,N,Z,C}; bits [7:4] ignored.
- `save`  in  1  interrupt entry: push {I,N,Z,C}, then clear I.
- `restore`  in  1  return from interrupt: pop the top entry into {I,N,Z,C}.
- `err_clr`  in  1  clears the sticky error bits.
- `carry`, `zero`, `neg`, `ie`  out  1 each  registered flags; `carry` drives the ALU `cin`.
- `status`  out  8  {4'b0, I, N, Z, C}, for register-file reads.
- `full`, `empty`  out  1 each  shadow stack occupancy.
- `ovf_err`, `unf_err`  out  1 each  sticky overflow and underflow errors.

## Operation
- State: flags C, Z, N, I; stack array `DEPTH`×4; stack pointer `sp` (0..DEPTH); two sticky error bits.
- One command class acts per cycle, in this priority order:
  1. `restore`
  2. `save`
  3. `st_we`
  4. flag and IE updates (`fl_we`, `sc`/`cc`, `ie_set`/`ie_clr`)
- Lower-priority inputs in the same cycle are ignored entirely.
- Flag update class:
  - each `fl_we` bit loads its ALU flag;
  - `sc` forces C=1 and `cc` forces C=0, both overriding `fl_we[2]`;
  - `sc` and `cc` together leave C unchanged unless `fl_we[2]` is set;
  - `ie_set` and `ie_clr` together leave I unchanged.
- `save` not full: stack[sp] ← {I,N,Z,C}, sp+1, I ← 0; C, Z, N unchanged.
- `save` full: no push, sp unchanged, I ← 0, `ovf_err` set.
- `restore` not empty: {I,N,Z,C} ← stack[sp−1], sp−1.
- `restore` empty: flags unchanged, `unf_err` set.
- `save` and `restore` in the same cycle: restore only; save is dropped.
- `full` = (sp==DEPTH); `empty` = (sp==0). Both are combinational from `sp`.
- `err_clr` clears both sticky bits. An error event in the same cycle wins, so the bit stays set.
- `st_we` never touches `sp`.

## Timing
- Reset (asynchronous, `rst`=0): C=Z=N=I=0, sp=0, errors 0.
  - Outputs at reset: `status`=8'h00, `empty`=1, `full`=0.
  - Stack contents are don't-care.
- All outputs are registered, or decoded from registers only. There is no combinational path from any input to any output.
- Latency is one cycle: an update sampled at edge k is visible after edge k. An ALU op in cycle k sees the carry written at edge k−1.
- Asserting reset mid-sequence abandons all stacked entries.
- `sp` never wraps in either direction.

## Configuration
- `STATUS_SHADOW_EN` defined: shadow stack, `sp`, `full`/`empty` and both error bits are implemented as above.
- Not defined: no stack storage is built and `DEPTH` is unused.
  - `save` only clears I.
  - `restore` only sets I; C, Z, N are unchanged.
  - `full`, `ovf_err`, `unf_err` are tied to 0 and `empty` is tied to 1.
  - Command priority is unchanged.

## Test plan
- Reset, then `fl_we`=3'b111 with cout=1, zout=0, nout=1 → next cycle `status`=8'h05 (N=1, C=1) and `carry`=1.
- I=1, C=1; `save`; then `fl_we`=3'b111 with all ALU flags 0; then `restore` → `status` sequence 8'h09, 8'h01, 8'h00, 8'h09; `empty` is 1 at the end.
- DEPTH=4: 5× `save` → `full`=1 after the 4th; 5th sets `ovf_err`=1 and sp stays 4. Then 5× `restore` → the 5th sets `unf_err`=1. Then `err_clr` → both 0.
- `sc`, `cc` and `fl_we[2]` together with cout=1 → C=1. Same cycle: `ie_set`+`ie_clr` → I unchanged.
- `save`+`restore`+`st_we` together with one entry stacked → flags = popped entry, sp=0, and `st_din` ignored.
- `rst` pulsed low mid-stack with sp=2, asynchronous to `clk` → outputs reset immediately without waiting for an edge; `empty`=1.
